// File: rtl/cmd_interp_ctrl.sv
// Calculator command sequencer: collects operand A, an operator and operand B from a
// decoded ASCII character stream, runs one start/done handshake with the ALU and holds
// the result for display. ESC aborts and clears from any state.
// Optional build macro CMD_CHAIN_EN: an operator typed while a good result is shown
// reuses that result as operand A of a new calculation.
module cmd_interp_ctrl #(
  parameter int unsigned W       = 16,
  parameter int unsigned MAX_DIG = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         rx_valid_i,
  input  logic [7:0]   data_i,
  input  logic         got_dig_i,
  input  logic         got_op_i,
  input  logic         got_eq_i,
  input  logic         got_esc_i,
  input  logic         alu_done_i,
  input  logic [W-1:0] alu_result_i,
  input  logic         alu_err_i,
  output logic [W-1:0] opnd_a_o,
  output logic [W-1:0] opnd_b_o,
  output logic [1:0]   op_code_o,
  output logic         alu_start_o,
  output logic [W-1:0] result_o,
  output logic         result_valid_o,
  output logic         err_o,
  output logic         busy_o
);

  localparam int unsigned    CntW   = $clog2(MAX_DIG + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_DIG);

  localparam logic [1:0] StA    = 2'd0;
  localparam logic [1:0] StB    = 2'd1;
  localparam logic [1:0] StExec = 2'd2;
  localparam logic [1:0] StRes  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    opnd_a_q, opnd_a_d;
  logic [W-1:0]    opnd_b_q, opnd_b_d;
  logic [1:0]      op_code_q, op_code_d;
  logic [CntW-1:0] a_cnt_q, a_cnt_d;
  logic [CntW-1:0] b_cnt_q, b_cnt_d;
  logic [W-1:0]    result_q, result_d;
  logic            err_q, err_d;
  logic            alu_start_q, alu_start_d;
  logic            result_valid_q, result_valid_d;
  logic            busy_q, busy_d;

  // Prioritised events: esc > eq > op > dig. An unknown operator still masks a digit flag.
  logic ev_esc, ev_eq, ev_op, ev_dig;
  assign ev_esc = rx_valid_i & got_esc_i;
  assign ev_eq  = rx_valid_i & got_eq_i & ~got_esc_i;
  assign ev_op  = rx_valid_i & got_op_i & ~got_eq_i & ~got_esc_i;
  assign ev_dig = rx_valid_i & got_dig_i & ~got_op_i & ~got_eq_i & ~got_esc_i;

  // Digit value and decimal shift-accumulate, truncated to W bits.
  logic [7:0]   dig8;
  logic [W-1:0] dig_w, acc_a, acc_b;
  assign dig8  = data_i - 8'h30;
  assign dig_w = W'(dig8);
  assign acc_a = opnd_a_q * W'(10) + dig_w;
  assign acc_b = opnd_b_q * W'(10) + dig_w;

  // Operator character to op_code; op_ok low for characters that are not + - * /.
  logic       op_ok;
  logic [1:0] op_enc;
  always_comb begin
    op_ok  = 1'b1;
    op_enc = 2'b00;
    case (data_i)
      8'h2B:   op_enc = 2'b00;
      8'h2D:   op_enc = 2'b01;
      8'h2A:   op_enc = 2'b10;
      8'h2F:   op_enc = 2'b11;
      default: op_ok  = 1'b0;
    endcase
  end

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d     = state_q;
    opnd_a_d    = opnd_a_q;
    opnd_b_d    = opnd_b_q;
    op_code_d   = op_code_q;
    a_cnt_d     = a_cnt_q;
    b_cnt_d     = b_cnt_q;
    result_d    = result_q;
    err_d       = err_q;
    alu_start_d = 1'b0;

    if (ev_esc) begin
      // Abort; a late alu_done in StExec is dropped because we leave that state now.
      state_d   = StA;
      opnd_a_d  = '0;
      opnd_b_d  = '0;
      op_code_d = 2'b00;
      a_cnt_d   = '0;
      b_cnt_d   = '0;
      result_d  = '0;
      err_d     = 1'b0;
    end else begin
      unique case (state_q)
        StA: begin
          if (ev_op && op_ok) begin
            op_code_d = op_enc;
            state_d   = StB;
          end else if (ev_dig && (a_cnt_q < MaxCnt)) begin
            opnd_a_d = acc_a;
            a_cnt_d  = a_cnt_q + CntW'(1);
          end
        end
        StB: begin
          if (ev_eq) begin
            if (b_cnt_q != '0) begin
              alu_start_d = 1'b1;
              state_d     = StExec;
            end
          end else if (ev_op) begin
            if (op_ok && (b_cnt_q == '0)) op_code_d = op_enc;
          end else if (ev_dig && (b_cnt_q < MaxCnt)) begin
            opnd_b_d = acc_b;
            b_cnt_d  = b_cnt_q + CntW'(1);
          end
        end
        StExec: begin
          if (alu_done_i) begin
            result_d = alu_result_i;
            err_d    = alu_err_i;
            state_d  = StRes;
          end
        end
        StRes: begin
          if (ev_op) begin
`ifdef CMD_CHAIN_EN
            // Chain on a good result; operand A is full so further digits go to B.
            if (op_ok && !err_q) begin
              opnd_a_d  = result_q;
              a_cnt_d   = MaxCnt;
              opnd_b_d  = '0;
              b_cnt_d   = '0;
              op_code_d = op_enc;
              state_d   = StB;
            end
`endif
          end else if (ev_dig) begin
            // A fresh digit starts a new calculation with that digit as operand A.
            state_d   = StA;
            opnd_a_d  = dig_w;
            a_cnt_d   = CntW'(1);
            opnd_b_d  = '0;
            b_cnt_d   = '0;
            op_code_d = 2'b00;
            result_d  = '0;
            err_d     = 1'b0;
          end
        end
        default: state_d = StA;
      endcase
    end

    result_valid_d = (state_d == StRes);
    busy_d         = (state_d == StExec);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StA;
      opnd_a_q       <= '0;
      opnd_b_q       <= '0;
      op_code_q      <= 2'b00;
      a_cnt_q        <= '0;
      b_cnt_q        <= '0;
      result_q       <= '0;
      err_q          <= 1'b0;
      alu_start_q    <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      opnd_a_q       <= opnd_a_d;
      opnd_b_q       <= opnd_b_d;
      op_code_q      <= op_code_d;
      a_cnt_q        <= a_cnt_d;
      b_cnt_q        <= b_cnt_d;
      result_q       <= result_d;
      err_q          <= err_d;
      alu_start_q    <= alu_start_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign opnd_a_o       = opnd_a_q;
  assign opnd_b_o       = opnd_b_q;
  assign op_code_o      = op_code_q;
  assign alu_start_o    = alu_start_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign err_o          = err_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_cmd_interp_ctrl.sv
// Bench for cmd_interp_ctrl: directed scenarios plus a random character/ALU stream,
// all checked against a calculator model written with plain integers.
module tb_cmd_interp_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        got_dig_i = 1'b0, got_op_i = 1'b0, got_eq_i = 1'b0, got_esc_i = 1'b0;
  logic        alu_done_i = 1'b0;
  logic [15:0] alu_result_i = 16'h0;
  logic        alu_err_i = 1'b0;
  logic [15:0] opnd_a_o, opnd_b_o, result_o;
  logic [1:0]  op_code_o;
  logic        alu_start_o, result_valid_o, err_o, busy_o;

  int checks = 0;
  int errors = 0;

  cmd_interp_ctrl #(.W(16), .MAX_DIG(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_valid_i(rx_valid_i), .data_i(data_i),
    .got_dig_i(got_dig_i), .got_op_i(got_op_i), .got_eq_i(got_eq_i), .got_esc_i(got_esc_i),
    .alu_done_i(alu_done_i), .alu_result_i(alu_result_i), .alu_err_i(alu_err_i),
    .opnd_a_o(opnd_a_o), .opnd_b_o(opnd_b_o), .op_code_o(op_code_o),
    .alu_start_o(alu_start_o), .result_o(result_o), .result_valid_o(result_valid_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Calculator model: mode 0 entering A, 1 entering B, 2 waiting on ALU, 3 showing result.
  int m_mode, m_a, m_b, m_op, m_acnt, m_bcnt, m_res, m_err, m_start;

  task automatic model_clear();
    m_mode = 0; m_a = 0; m_b = 0; m_op = 0; m_acnt = 0; m_bcnt = 0;
    m_res = 0; m_err = 0; m_start = 0;
  endtask

  // fl = {dig, op, eq, esc}
  function automatic logic [3:0] dec(input logic [7:0] ch);
    dec = {(ch >= 8'h30 && ch <= 8'h39), (ch >= 8'h2A && ch <= 8'h2F), ch == 8'h3D,
           ch == 8'h1B};
  endfunction

  task automatic model_step(input bit rx, input logic [7:0] ch, input logic [3:0] fl,
                            input bit done, input logic [15:0] r, input bit e);
    int d, code;
    d = int'(8'(ch - 8'h30));
    code = (ch == 8'h2B) ? 0 : (ch == 8'h2D) ? 1 : (ch == 8'h2A) ? 2 : (ch == 8'h2F) ? 3 : -1;
    m_start = 0;
    if (rx && fl[0]) begin
      model_clear();
    end else if (m_mode == 2) begin
      if (done) begin m_res = r; m_err = e; m_mode = 3; end
    end else if (rx && fl[1]) begin
      if (m_mode == 1 && m_bcnt > 0) begin m_start = 1; m_mode = 2; end
    end else if (rx && fl[2]) begin
      if (code >= 0) begin
        if (m_mode == 0) begin m_op = code; m_mode = 1; end
        else if (m_mode == 1 && m_bcnt == 0) m_op = code;
`ifdef CMD_CHAIN_EN
        else if (m_mode == 3 && m_err == 0) begin
          m_a = m_res; m_acnt = 4; m_b = 0; m_bcnt = 0; m_op = code; m_mode = 1;
        end
`endif
      end
    end else if (rx && fl[3]) begin
      if (m_mode == 0 && m_acnt < 4) begin m_a = (m_a * 10 + d) % 65536; m_acnt++; end
      else if (m_mode == 1 && m_bcnt < 4) begin m_b = (m_b * 10 + d) % 65536; m_bcnt++; end
      else if (m_mode == 3) begin
        model_clear(); m_a = d; m_acnt = 1;
      end
    end
  endtask

  // One clock: apply inputs at negedge, update model at posedge, settle 1 time unit.
  task automatic drive(input bit rx, input logic [7:0] ch, input logic [3:0] fl,
                       input bit done, input logic [15:0] r, input bit e);
    @(negedge clk_i);
    rx_valid_i = rx; data_i = ch;
    {got_dig_i, got_op_i, got_eq_i, got_esc_i} = rx ? fl : 4'b0;
    alu_done_i = done; alu_result_i = r; alu_err_i = e;
    @(posedge clk_i);
    model_step(rx, ch, fl, done, r, e);
    #1;
    rx_valid_i = 1'b0; {got_dig_i, got_op_i, got_eq_i, got_esc_i} = 4'b0; alu_done_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] ch);
    drive(1'b1, ch, dec(ch), 1'b0, 16'h0, 1'b0);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(8'(s[i]));
  endtask

  task automatic alu_reply(input logic [15:0] r, input bit e);
    drive(1'b0, 8'h00, 4'b0, 1'b1, r, e);
  endtask

  task automatic test_reset();
    logic [53:0] act;
    act = {opnd_a_o, opnd_b_o, op_code_o, alu_start_o, result_o, result_valid_o, err_o, busy_o};
    checks++;
    if (act !== 54'h0) begin errors++; $display("FAIL reset_init: got %h want 0", act); end
    send_str("12");
    checks++;
    if (opnd_a_o !== 16'd12) begin
      errors++; $display("FAIL reset_pre_a: got %0d want 12", opnd_a_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    model_clear();
    act = {opnd_a_o, opnd_b_o, op_code_o, alu_start_o, result_o, result_valid_o, err_o, busy_o};
    checks++;
    if (act !== 54'h0) begin errors++; $display("FAIL reset_async: got %h want 0", act); end
    @(negedge clk_i); rst_ni = 1'b1;
    send_str("3+");
    checks++;
    if (opnd_a_o !== 16'd3 || result_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_state_a: a=%0d rv=%b want a=3 rv=0", opnd_a_o, result_valid_o);
    end
    send(8'h1B);
  endtask

  task automatic test_basic();
    send_str("12+34=");
    checks++;
    if ({opnd_a_o, opnd_b_o, op_code_o, alu_start_o, busy_o} !== {16'd12, 16'd34, 2'b00, 2'b11})
    begin
      errors++;
      $display("FAIL basic_start: a=%0d b=%0d op=%b st=%b busy=%b want 12 34 00 1 1",
               opnd_a_o, opnd_b_o, op_code_o, alu_start_o, busy_o);
    end
    alu_reply(16'd46, 1'b0);
    checks++;
    if ({alu_start_o, result_o, result_valid_o, err_o, busy_o} !== {1'b0, 16'd46, 3'b100}) begin
      errors++;
      $display("FAIL basic_result: st=%b res=%0d rv=%b err=%b busy=%b want 0 46 1 0 0",
               alu_start_o, result_o, result_valid_o, err_o, busy_o);
    end
    send(8'h1B);
  endtask

  task automatic test_digit_limit();
    send_str("12345");
    checks++;
    if (opnd_a_o !== 16'd1234) begin
      errors++; $display("FAIL dig_limit_a: got %0d want 1234", opnd_a_o);
    end
    send_str("-7=");
    checks++;
    if ({opnd_a_o, opnd_b_o, op_code_o, alu_start_o} !== {16'd1234, 16'd7, 2'b01, 1'b1}) begin
      errors++;
      $display("FAIL dig_limit_b: a=%0d b=%0d op=%b st=%b want 1234 7 01 1",
               opnd_a_o, opnd_b_o, op_code_o, alu_start_o);
    end
    alu_reply(16'd1227, 1'b0);
    send(8'h1B);
  endtask

  task automatic test_op_replace();
    send_str("9+*,.");
    checks++;
    if (op_code_o !== 2'b10) begin
      errors++; $display("FAIL op_replace: got %b want 10", op_code_o);
    end
    send(8'h3D);
    checks++;
    if (alu_start_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL eq_no_b: st=%b busy=%b want 0 0", alu_start_o, busy_o);
    end
    send_str("3-=");
    checks++;
    if ({op_code_o, opnd_b_o, alu_start_o} !== {2'b10, 16'd3, 1'b1}) begin
      errors++;
      $display("FAIL op_locked: op=%b b=%0d st=%b want 10 3 1", op_code_o, opnd_b_o, alu_start_o);
    end
    alu_reply(16'd27, 1'b1);
    send(8'h2B);
    checks++;
    if ({result_valid_o, err_o, result_o, opnd_a_o} !== {2'b11, 16'd27, 16'd9}) begin
      errors++;
      $display("FAIL err_op_ignored: rv=%b err=%b res=%0d a=%0d want 1 1 27 9",
               result_valid_o, err_o, result_o, opnd_a_o);
    end
    send(8'h1B);
  endtask

  task automatic test_esc_exec();
    send_str("1+2=");
    send(8'h1B);
    checks++;
    if ({busy_o, opnd_a_o, opnd_b_o, result_valid_o} !== {1'b0, 32'd0, 1'b0}) begin
      errors++; $display("FAIL esc_exec: busy=%b a=%0d b=%0d", busy_o, opnd_a_o, opnd_b_o);
    end
    alu_reply(16'd99, 1'b0);
    idle_check("esc_late_done");
  endtask

  task automatic idle_check(input string nm);
    drive(1'b0, 8'h00, 4'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (result_valid_o !== 1'b0 || result_o !== 16'd0) begin
      errors++; $display("FAIL %s: rv=%b res=%0d want 0 0", nm, result_valid_o, result_o);
    end
  endtask

  task automatic test_chain();
    send_str("5+5=");
    alu_reply(16'd10, 1'b0);
    send(8'h2A);
`ifdef CMD_CHAIN_EN
    send_str("3=");
    checks++;
    if ({opnd_a_o, opnd_b_o, op_code_o, alu_start_o} !== {16'd10, 16'd3, 2'b10, 1'b1}) begin
      errors++;
      $display("FAIL chain: a=%0d b=%0d op=%b st=%b want 10 3 10 1",
               opnd_a_o, opnd_b_o, op_code_o, alu_start_o);
    end
    alu_reply(16'd30, 1'b0);
`else
    checks++;
    if ({result_valid_o, result_o, op_code_o, opnd_a_o} !== {1'b1, 16'd10, 2'b00, 16'd5}) begin
      errors++;
      $display("FAIL no_chain_op: rv=%b res=%0d op=%b a=%0d want 1 10 00 5",
               result_valid_o, result_o, op_code_o, opnd_a_o);
    end
    send(8'h33);
    checks++;
    if ({opnd_a_o, opnd_b_o, result_valid_o, result_o} !== {16'd3, 16'd0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL no_chain_dig: a=%0d b=%0d rv=%b res=%0d want 3 0 0 0",
               opnd_a_o, opnd_b_o, result_valid_o, result_o);
    end
`endif
    send(8'h1B);
  endtask

  task automatic test_random();
    logic [7:0]  pool [17] = '{8'h30, 8'h31, 8'h32, 8'h35, 8'h37, 8'h39, 8'h34, 8'h38,
                               8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h2C, 8'h2E, 8'h3D, 8'h3D, 8'h1B};
    logic [53:0] act, exp;
    logic [7:0]  ch;
    logic [3:0]  fl;
    for (int i = 0; i < 600; i++) begin
      if (m_mode == 2 && $urandom_range(0, 2) == 0) begin
        drive(1'b0, 8'h00, 4'b0, 1'b1, 16'($urandom), 1'($urandom));
      end else if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 8'h00, 4'b0, $urandom_range(0, 9) == 0, 16'($urandom), 1'($urandom));
      end else begin
        ch = pool[$urandom_range(0, 16)];
        if (ch == 8'h1B && $urandom_range(0, 2) != 0) ch = 8'h34;
        fl = dec(ch);
        if ($urandom_range(0, 9) == 0) fl = fl | 4'($urandom) & 4'b1110;
        drive(1'b1, ch, fl, 1'b0, 16'h0, 1'b0);
      end
      exp = {16'(m_a), 16'(m_b), 2'(m_op), m_start != 0, 16'(m_res), m_mode == 3, m_err != 0,
             m_mode == 2};
      act = {opnd_a_o, opnd_b_o, op_code_o, alu_start_o, result_o, result_valid_o, err_o, busy_o};
      checks++;
      if (act !== exp) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", i, act, exp);
      end
    end
  endtask

  initial begin
    model_clear();
    #12 rst_ni = 1'b1;
    test_reset();
    test_basic();
    test_digit_limit();
    test_op_replace();
    test_esc_exec();
    test_chain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_interp_ctrl.md
Name: cmd_interp_ctrl

Overview:
- Calculator command sequencer between the ASCII command decoder and the arithmetic unit.
- Consumes one character per rx_valid strobe, qualified by the decoder flags (got_dig/got_op/got_eq/got_esc).
- Accumulates two decimal operands and an operator, issues a start/done handshake to the ALU, and holds the result for display.
- Escape aborts and clears at any point.

Parameters:
- W, 16, operand/result width in bits.
- MAX_DIG, 4, max decimal digits per operand; requires 10^MAX_DIG-1 < 2^W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: data and decoder flags valid this cycle.
- data  in  8  ASCII character.
- got_dig  in  1  decoder: data is '0'..'9'.
- got_op  in  1  decoder: data is an operator character.
- got_eq  in  1  decoder: data is '='.
- got_esc  in  1  decoder: data is ESC (8'h1B).
- alu_done  in  1  one-cycle pulse: ALU result ready.
- alu_result  in  W  ALU result, valid with alu_done.
- alu_err  in  1  ALU error (e.g. divide by zero), valid with alu_done.
- opnd_a  out  W  operand A.
- opnd_b  out  W  operand B.
- op_code  out  2  00 add (8'h2B), 01 sub (8'h2D), 10 mul (8'h2A), 11 div (8'h2F).
- alu_start  out  1  one-cycle start pulse to ALU.
- result  out  W  latched result.
- result_valid  out  1  high while in S_RES.
- err  out  1  latched alu_err, high while in S_RES.
- busy  out  1  high in S_EXEC.

Behaviour:
- All outputs registered. On reset: state S_A; opnd_a, opnd_b, op_code, result = 0; alu_start, result_valid, err, busy = 0; digit counters = 0.
- Events are taken only when rx_valid=1.
- Priority when several flags are set: esc > eq > op > dig.
- got_op with data not in {2B, 2D, 2A, 2F} (e.g. 2C, 2E) is ignored.
- Digit value = data - 8'h30. Accumulate: X <= X*10 + d. Result is truncated to W bits (cannot overflow given the MAX_DIG constraint).
- esc in any state: clear opnd_a, opnd_b, op_code, counters, result, err; go to S_A next cycle. In S_EXEC a late alu_done is discarded.

State S_A (enter A):
- dig: accumulate into opnd_a if a_cnt < MAX_DIG, else ignore.
- op: latch op_code, go to S_B. Allowed with a_cnt = 0 (A = 0).
- eq: ignored.

State S_B (enter B):
- dig: accumulate into opnd_b if b_cnt < MAX_DIG, else ignore.
- op with b_cnt = 0: replace op_code. op with b_cnt > 0: ignored.
- eq with b_cnt > 0: alu_start = 1 for exactly the next cycle; busy = 1; go to S_EXEC.
- eq with b_cnt = 0: ignored.

State S_EXEC:
- Only esc is honoured; dig/op/eq are ignored.
- On alu_done: result <= alu_result, err <= alu_err, busy = 0; go to S_RES. result_valid rises the cycle after alu_done.
- No timeout.

State S_RES:
- result_valid = 1.
- dig: clear all; opnd_a = digit, a_cnt = 1; go to S_A.
- eq: ignored.
- op: see Optional Feature.

Latency:
- '=' accepted -> alu_start high on the following cycle.
- alu_done -> result_valid high on the following cycle.

Optional Feature:
- Macro: CMD_CHAIN_EN.
- Defined: op in S_RES with err = 0 sets opnd_a = result, a_cnt = MAX_DIG, clears opnd_b and b_cnt, latches op_code, goes to S_B. With err = 1, op is ignored.
- Not defined: op in S_RES is ignored; only dig or esc leave S_RES.

Test Plan:
- Reset mid-operation: after '1','2' in S_A, assert rst=0 -> all outputs 0 immediately, state S_A.
- "12+34=" with alu_done one cycle later, alu_result=46 -> opnd_a=12, opnd_b=34, op_code=00, single-cycle alu_start, then result=46, result_valid=1, err=0.
- "12345" in S_A, then "-" "7" "=" -> opnd_a=1234 (fifth digit dropped), op_code=01, opnd_b=7.
- "9", "+", "*", "3", "=" -> op_code=10 (operator replaced). Then ',' '.' with got_op -> ignored. "=" with b_cnt=0 -> no alu_start.
- esc during S_EXEC, then alu_done -> state S_A, result=0, result_valid never asserts.
- CMD_CHAIN_EN: "5+5=" with result 10, then "*", "3", "=" -> opnd_a=10, opnd_b=3, op_code=10. Without the macro, "*" in S_RES -> no change; next "3" -> opnd_a=3, state S_A.
